serial_add_sub: RTL and testbench

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub_if.sv | 36 +++
 rtl/serial_add_sub.sv | 145 ++++++++++++++
 tb/tb_serial_add_sub.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Bus bundle for serial_add_sub: operation request, operands, status and result.
// The ovf signal exists only when SERIAL_ADD_SUB_OVF_EN is defined.
interface serial_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf;
`endif

  // Requester side: drives the operation, observes status and result.
  modport master (
    output start, a, b, mode, cin,
`ifdef SERIAL_ADD_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, result, cout
  );

  // Adder side: receives the operation, produces status and result.
  modport slave (
    input  start, a, b, mode, cin,
`ifdef SERIAL_ADD_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, result, cout
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one bit per clock, LSB first.
// Accepting start in IDLE captures the operands and runs WIDTH SHIFT cycles,
// then a single DONE cycle pulses done with result/cout valid. Subtraction is
// a + ~b + ~cin, so cout=1 means "no borrow".
// Optional feature: define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow
// output ovf (carry into MSB XOR carry out of MSB), held like cout.
module serial_add_sub #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_nxt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One full-adder slice; subtraction inverts the b bit.
  always_comb begin
    a_bit     = a_q[cnt_q];
    b_bit     = b_q[cnt_q] ^ mode_q;
    sum_bit   = a_bit ^ b_bit ^ carry_q;
    carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
  end

  // Operand capture on acceptance; held untouched for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      mode_q <= bus.mode;
    end
  end

  // Bit counter and running carry; carry seeds with cin (add) or ~cin (sub).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= bus.cin ^ bus.mode;
    end else if (state_q == SHIFT) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      carry_q <= carry_nxt;
    end
  end

  // Result shift register fills from the top so bit i lands at result[i]
  // after WIDTH shifts; cout (and ovf) load on the final bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (state_q == SHIFT) begin
      result_q <= {sum_bit, result_q[WIDTH-1:1]};
      if (last_bit) begin
        cout_q <= carry_nxt;
`ifdef SERIAL_ADD_SUB_OVF_EN
        ovf_q  <= carry_q ^ carry_nxt;
`endif
      end
    end
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH=16): directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_serial_add_sub;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Plain-integer reference: add = a+b+cin, sub = a-b-cin; cout = carry /
  // no-borrow; ovf = true signed result outside the 16-bit range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic c, output logic [W-1:0] res, output logic co,
                       output logic ov);
    int ua, ub, full, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!m) begin
      full = ua + ub + int'(c);
      co   = (full >= 65536);
      s    = sa + sb + int'(c);
    end else begin
      full = ua - ub - int'(c);
      co   = (full >= 0);
      s    = sa - sb - int'(c);
    end
    res = W'(full & 32'hFFFF);
    ov  = (s > 32767) || (s < -32768);
  endtask

  // Issue one operation and wait (bounded) for done. lat is the edge count
  // after acceptance at which done is high (0 = never seen). Returns once the
  // FSM is back in IDLE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                        input logic ic, output int lat, output int busy_cnt,
                        output logic [W-1:0] res, output logic co, output logic ov);
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.mode = im; bus.cin = ic; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; busy_cnt = 0; res = '0; co = 1'b0; ov = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = n + 1;
        res = bus.result;
        co  = bus.cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
        ov  = bus.ovf;
`endif
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat, bcnt, dcnt, first_done, prev_done, bad_iv, bad_res, bad_hold;
    logic [W-1:0] res, eres;
    logic         co, ov, eco, eov;

    n_pass = 0; n_total = 0;
    vecs[0] = '{a:16'h1234, b:16'h0FED, mode:1'b0, cin:1'b0, res:16'h2221, cout:1'b0, ovf:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, mode:1'b0, cin:1'b1, res:16'h0001, cout:1'b1, ovf:1'b0};
    vecs[2] = '{a:16'h7FFF, b:16'h0001, mode:1'b0, cin:1'b0, res:16'h8000, cout:1'b0, ovf:1'b1};
    vecs[3] = '{a:16'h0005, b:16'h0007, mode:1'b1, cin:1'b0, res:16'hFFFE, cout:1'b0, ovf:1'b0};
    vecs[4] = '{a:16'h0010, b:16'h0001, mode:1'b1, cin:1'b1, res:16'h000E, cout:1'b1, ovf:1'b0};
    vecs[5] = '{a:16'h8000, b:16'h8000, mode:1'b0, cin:1'b0, res:16'h0000, cout:1'b1, ovf:1'b1};
    vecs[6] = '{a:16'h8000, b:16'h0001, mode:1'b1, cin:1'b0, res:16'h7FFF, cout:1'b1, ovf:1'b1};
    vecs[7] = '{a:16'h0000, b:16'h0000, mode:1'b1, cin:1'b1, res:16'hFFFF, cout:1'b0, ovf:1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.cin = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_cout",   32'(bus.cout),   32'd0);
`ifdef SERIAL_ADD_SUB_OVF_EN
    check("reset_ovf",    32'(bus.ovf),    32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].cin, lat, bcnt, res, co, ov);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_cout", i),   32'(co),  32'(vecs[i].cout));
`ifdef SERIAL_ADD_SUB_OVF_EN
      check($sformatf("vec%0d_ovf", i),    32'(ov),  32'(vecs[i].ovf));
`endif
      check($sformatf("vec%0d_latency", i), 32'(lat),  32'd17);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd16);
      check($sformatf("vec%0d_idle_hold", i), 32'(bus.result), 32'(vecs[i].res));
    end

    // Start pulsed mid-operation must be ignored
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0FED; bus.mode = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dcnt = 0; lat = 0; res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.mode = 1'b1; bus.cin = 1'b1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dcnt++;
        if (lat == 0) begin
          lat = n + 1;
          res = bus.result;
        end
      end
    end
    check("ignore_start_result",  32'(res),  32'h2221);
    check("ignore_start_latency", 32'(lat),  32'd17);
    check("ignore_start_dones",   32'(dcnt), 32'd1);

    // Reset during SHIFT aborts the operation
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0FED; bus.mode = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_cout",   32'(bus.cout),   32'd0);
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, bcnt, res, co, ov);
    check("post_rst_result",  32'(res), 32'h0002);
    check("post_rst_latency", 32'(lat), 32'd17);

    // start held high: back-to-back operations every 18 cycles
    @(negedge clk);
    bus.a = 16'h0003; bus.b = 16'h0004; bus.mode = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    dcnt = 0; first_done = -1; prev_done = -1; bad_iv = 0; bad_res = 0; bad_hold = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dcnt++;
        if (bus.result !== 16'h0007) bad_res++;
        if (prev_done >= 0 && (n - prev_done) != 18) bad_iv++;
        if (first_done < 0) first_done = n;
        prev_done = n;
      end else if (first_done >= 0 && !bus.busy && bus.result !== 16'h0007) begin
        bad_hold++;
      end
    end
    @(negedge clk) bus.start = 1'b0;
    check("held_start_first_done", 32'(first_done), 32'd17);
    check("held_start_pulses",     32'(dcnt),       32'd4);
    check("held_start_interval",   32'(bad_iv),     32'd0);
    check("held_start_result",     32'(bad_res),    32'd0);
    check("held_start_idle_hold",  32'(bad_hold),   32'd0);
    repeat (20) @(posedge clk);
    #1;

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rm, rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (i < 4) begin
        ra = (i[0]) ? 16'hFFFF : 16'h8000;
        rb = (i[1]) ? 16'hFFFF : 16'h7FFF;
      end
      model(ra, rb, rm, rc, eres, eco, eov);
      run_op(ra, rb, rm, rc, lat, bcnt, res, co, ov);
      check($sformatf("rand%0d_result a=%h b=%h m=%0d c=%0d", i, ra, rb, rm, rc), 32'(res), 32'(eres));
      check($sformatf("rand%0d_cout", i), 32'(co), 32'(eco));
`ifdef SERIAL_ADD_SUB_OVF_EN
      check($sformatf("rand%0d_ovf", i), 32'(ov), 32'(eov));
`endif
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd17);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
